// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives a 2-input gate through all four input
// vectors, samples its output after a settle time and scores it.
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECT        = 4'b1110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       first_fail_valid,
    output logic [1:0] first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic [1:0] idx_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [1:0] ab_nxt;
    logic       mismatch;
    logic [2:0] err_nxt;
    logic       accept;
    logic       last_vec;

    // Compare only matters in SAMPLE; err_nxt is the post-sample count.
    assign mismatch = (c != EXPECT[idx]);
    assign err_nxt  = err_count + {2'b00, mismatch};
    assign accept   = (state == IDLE) && start;
    assign last_vec = (idx == 2'd3);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, next vector index and settle counter.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = APPLY;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = RELOAD;
                end
            end
            APPLY: begin
                if (cnt == 4'd0) begin
                    state_nxt = SAMPLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            SAMPLE: begin
                if (last_vec) begin
                    state_nxt = REPORT;
                end else begin
                    state_nxt = APPLY;
                    idx_nxt   = idx + 2'd1;
                    cnt_nxt   = RELOAD;
                end
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        ab_nxt = 2'b00;
        unique case (state)
            APPLY, SAMPLE: busy = 1'b1;
            REPORT:        done = 1'b1;
            default:       busy = 1'b0;
        endcase
        if (state_nxt == APPLY || state_nxt == SAMPLE) begin
            ab_nxt = idx_nxt;
        end
    end

    // Vector index, settle counter and registered stimulus.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= 2'd0;
            cnt <= 4'd0;
            a   <= 1'b0;
            b   <= 1'b0;
        end else begin
            idx <= idx_nxt;
            cnt <= cnt_nxt;
            a   <= ab_nxt[1];
            b   <= ab_nxt[0];
        end
    end

    // Result registers: cleared on accept, updated at each sample edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count        <= 3'd0;
            pass             <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 2'd0;
        end else if (accept) begin
            err_count        <= 3'd0;
            pass             <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 2'd0;
        end else if (state == SAMPLE) begin
            if (mismatch) begin
                err_count <= err_nxt;
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= idx;
                end
            end
            if (last_vec) begin
                pass <= (err_nxt == 3'd0);
            end
        end
    end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Self-checking stimulus and response stage for the 2-input gate blocks (or_gate, and_gate, and the rest of the family). It sits on both sides of the gate under test. Upstream, it drives the gate's a/b inputs through all four input combinations. Downstream, it samples the gate's c output after a programmable settle time, compares it against a parameterised truth table, and reports pass/fail with an error count and the first failing vector.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: cycles each vector is held before sampling. Legal range 1..15.
- EXPECT, default 4'b1110: expected c per vector. Bit i is the expected c for {a,b}=i. The default is the OR truth table.

Ports:
- clk  input  1  single clock; all logic is on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a check run; accepted only in IDLE
- a  output  1  registered stimulus to gate input a
- b  output  1  registered stimulus to gate input b
- c  input  1  gate output under check
- busy  output  1  high while a run is in progress (APPLY or SAMPLE)
- done  output  1  one-cycle pulse when results are final
- pass  output  1  1 when the last completed run had zero mismatches
- err_count  output  3  number of mismatching vectors, 0..4
- first_fail_valid  output  1  at least one mismatch in the last run
- first_fail_idx  output  2  vector index {a,b} of the first mismatch

## Operation
- FSM states:
  - IDLE: waits for start.
  - APPLY: holds the current vector for SETTLE_CYCLES cycles.
  - SAMPLE: one cycle; c is compared at the end of this cycle.
  - REPORT: one cycle; done=1.
- Internal registers: 2-bit vector index idx and 4-bit settle counter cnt.
- IDLE -> APPLY when start=1 at an edge. On that edge:
  - idx<=0 and cnt<=SETTLE_CYCLES-1.
  - err_count, pass, first_fail_valid and first_fail_idx are cleared.
- APPLY: cnt decrements each edge. At cnt==0 the next state is SAMPLE.
- SAMPLE: at its closing edge, mismatch = (c != EXPECT[idx]).
  - On mismatch: err_count increments. If first_fail_valid=0, it sets first_fail_valid=1 and first_fail_idx=idx.
  - If idx==3: next state is REPORT, and pass is loaded with (final err_count==0).
  - Otherwise: idx<=idx+1, cnt reloads, and the next state is APPLY.
- REPORT -> IDLE unconditionally. start is ignored in REPORT.
- a/b values: {a,b}=idx in APPLY and SAMPLE, and 0 in IDLE and REPORT. Both are registered outputs, with no combinational path from any input.
- busy=1 in APPLY and SAMPLE only. done=1 in REPORT only.
- start is ignored while busy, so there is no queuing. Holding start high produces back-to-back runs separated by the REPORT cycle plus one IDLE cycle.
- Result outputs hold their values from REPORT until the next accepted start.
- err_count saturation cannot occur: the maximum is 4 and it fits in 3 bits.

## Timing
- Reset values (rst=1 at any edge, including mid-run): state=IDLE and a=b=busy=done=pass=0, err_count=0, first_fail_valid=0, first_fail_idx=0. No done is issued for an aborted run. rst has priority over start.
- Let E0 be the start-accept edge. Each vector occupies SETTLE_CYCLES+1 cycles.
- Vector k is applied from edge E0+k·(SETTLE_CYCLES+1) and sampled at edge E0+(k+1)·(SETTLE_CYCLES+1).
- done is high from edge E0+4·(SETTLE_CYCLES+1) for exactly one cycle. With the default parameters, that is 12 cycles after E0.
- The earliest next accepted start is the edge two cycles after done rises.
- c must be stable for at least the SETTLE_CYCLES cycles before the sample edge. Combinational gates meet this trivially.

## Test plan
- Reset: hold rst for 2 cycles with start=1.
  - Required: a=b=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0 throughout.
- Good OR gate, default parameters, single start pulse.
  - Required: {a,b} sequence is 00,01,10,11, each held 3 cycles.
  - Required: done is a single pulse 12 cycles after E0, with pass=1, err_count=0, first_fail_valid=0.
- AND gate in place of OR (EXPECT=1110).
  - Required: mismatches at idx 1 and 2, giving err_count=2, first_fail_valid=1, first_fail_idx=1, pass=0.
- c stuck at 1 with EXPECT=1110, then a second run with a good gate.
  - Required for the first run: err_count=1, first_fail_idx=0.
  - Required for the second run: results are cleared at its start and it reports pass=1.
- start held high for 40 cycles with SETTLE_CYCLES=1.
  - Required: each run lasts 8 cycles with exactly one done pulse, and runs are separated by REPORT plus one IDLE cycle.
  - Required: start pulses during busy have no effect.
- rst asserted for 1 cycle while idx=2 is in APPLY.
  - Required: all outputs are at reset values on the next edge and no done appears.
  - A subsequent start must run all 4 vectors from idx 0.
